// File: rtl/debounce_pkg.sv
// Shared types and default timing for the multi-channel button debouncer.
// The optional auto-repeat event is enabled by defining DEBOUNCE_AUTO_REPEAT_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONG     = 2'd2
  } chan_state_e;

  // 10 ms debounce, 1 s long press, 200 ms repeat at 25 MHz.
  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_LONG_CYCLES     = 25000000;
  localparam int DEF_REPEAT_CYCLES   = 5000000;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchroniser, consecutive-sample filter, hold/long/repeat timing.
// Auto-repeat logic exists only when DEBOUNCE_AUTO_REPEAT_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic       repeat_o,
  output logic [1:0] state_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  logic              s0_q, s1_q;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic              level_q, level_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              press_q, release_q, long_q;
  logic              rise, fall, long_hit;
  chan_state_e       state_q, state_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s1_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = s1_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // Hold count saturates so a long press never retriggers.
  always_comb begin
    hold_d = hold_q;
    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_W'(LONG_CYCLES)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RELEASED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RELEASED: if (rise) state_d = ST_HELD;
      ST_HELD: begin
        if (fall) begin
          state_d = ST_RELEASED;
        end else if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
          state_d = ST_LONG;
        end
      end
      ST_LONG:     if (fall) state_d = ST_RELEASED;
      default:     state_d = ST_RELEASED;
    endcase
  end

  always_comb begin
    long_hit = (state_q == ST_HELD) && (state_d == ST_LONG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      s0_q      <= btn_i ^ ACTIVE_LOW;
      s1_q      <= s0_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      hold_q    <= hold_d;
      press_q   <= rise;
      release_q <= fall;
      long_q    <= long_hit;
    end
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_hit, rep_q;

  // Repeat period is measured from the long event and only while the level stays high.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_hit   = 1'b0;
    if (state_d != ST_LONG || long_hit) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
      rep_cnt_d = '0;
      rep_hit   = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_hit;
    end
  end

  assign repeat_o = rep_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign state_o   = state_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel filters merged into one event stream via sticky pending bits.
// Define DEBOUNCE_AUTO_REPEAT_EN to add EVT_REPEAT events during long presses.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  localparam int CH_W           = ch_width(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      btn_in,
  output logic [NUM_CH-1:0]      btn_level,
  output logic [NUM_CH-1:0]      btn_press,
  output logic [NUM_CH-1:0]      btn_release,
  output logic                   evt_valid,
  output logic [CH_W-1:0]        evt_ch,
  output evt_type_e              evt_type,
  input  logic                   evt_ready,
  output logic                   evt_overflow,
  input  logic                   ovf_clr,
  output logic [NUM_CH-1:0][1:0] dbg_state
);

  logic [NUM_CH-1:0]      long_pulse, rep_pulse;
  logic [NUM_CH-1:0][3:0] pend_q, pend_d, set_vec, pop_vec, ovf_vec;
  logic                   sel_valid_q;
  logic [CH_W-1:0]        sel_ch_q, pick_ch;
  evt_type_e              sel_type_q, pick_type;
  logic                   pick_found;
  logic                   ovf_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (btn_in[c]),
      .level_o   (btn_level[c]),
      .press_o   (btn_press[c]),
      .release_o (btn_release[c]),
      .long_o    (long_pulse[c]),
      .repeat_o  (rep_pulse[c]),
      .state_o   (dbg_state[c])
    );
  end

  // Pending bit positions follow the evt_type_e encoding.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      set_vec[c] = {rep_pulse[c], long_pulse[c], btn_release[c], btn_press[c]};
      pop_vec[c] = '0;
      if (sel_valid_q && evt_ready && (sel_ch_q == CH_W'(c))) begin
        pop_vec[c] = 4'b0001 << sel_type_q;
      end
      // A set on the bit being popped re-arms it without counting as a drop.
      ovf_vec[c] = set_vec[c] & pend_q[c] & ~pop_vec[c];
      pend_d[c]  = (pend_q[c] & ~pop_vec[c]) | set_vec[c];
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    pick_type  = EVT_PRESS;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!pick_found && (|pend_q[c])) begin
        pick_found = 1'b1;
        pick_ch    = CH_W'(c);
        if (pend_q[c][EVT_PRESS])       pick_type = EVT_PRESS;
        else if (pend_q[c][EVT_LONG])   pick_type = EVT_LONG;
        else if (pend_q[c][EVT_REPEAT]) pick_type = EVT_REPEAT;
        else                            pick_type = EVT_RELEASE;
      end
    end
  end

  // Handshake: an event transfers on a cycle with evt_valid && evt_ready; while
  // evt_valid is high and evt_ready low, evt_ch/evt_type hold and are never
  // replaced by newer or higher-priority events. A new pick is loaded only when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      sel_valid_q <= 1'b0;
      sel_ch_q    <= '0;
      sel_type_q  <= EVT_PRESS;
      ovf_q       <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (!sel_valid_q) begin
        sel_valid_q <= pick_found;
        if (pick_found) begin
          sel_ch_q   <= pick_ch;
          sel_type_q <= pick_type;
        end
      end else if (evt_ready) begin
        sel_valid_q <= 1'b0;
      end
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end else if (|ovf_vec) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign evt_valid    = sel_valid_q;
  assign evt_ch       = sel_ch_q;
  assign evt_type     = sel_type_q;
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with NUM_CH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
// Inputs change on falling edges; outputs are sampled on falling edges.
`timescale 1ns/1ps
module tb_debounce_multi;
  import debounce_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      btn_in = '0;
  logic [3:0]      btn_level, btn_press, btn_release;
  logic            evt_valid;
  logic [1:0]      evt_ch;
  logic [1:0]      evt_type;
  logic            evt_ready = 1'b0;
  logic            evt_overflow;
  logic            ovf_clr = 1'b0;
  logic [3:0][1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  always #5 clk = ~clk;

  debounce_multi #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b0), .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_type(evt_type),
    .evt_ready(evt_ready), .evt_overflow(evt_overflow), .ovf_clr(ovf_clr), .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (rst_n && evt_valid && evt_ready) obs_q.push_back({evt_ch, evt_type});
  end

  function automatic logic [3:0] ev(input int ch, input evt_type_e t);
    logic [1:0] c;
    c = 2'(ch);
    return {c, t};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_in = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    cycles(3);
    checks++; if (btn_level !== 4'h0) begin errors++; $display("FAIL reset_level: got %h expected 0", btn_level); end
    checks++; if (btn_press !== 4'h0) begin errors++; $display("FAIL reset_press: got %h expected 0", btn_press); end
    checks++; if (btn_release !== 4'h0) begin errors++; $display("FAIL reset_release: got %h expected 0", btn_release); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    checks++; if ({evt_ch, evt_type} !== 4'h0) begin errors++; $display("FAIL reset_evt: got %h expected 0", {evt_ch, evt_type}); end
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", evt_overflow); end
    checks++; if (dbg_state !== 8'h00) begin errors++; $display("FAIL reset_state: got %h expected 0", dbg_state); end
    rst_n = 1'b1;
    cycles(2);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", evt_valid); end
  endtask

  task automatic test_clean_press();
    evt_ready = 1'b1;
    btn_in[2] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (btn_level[2] !== (i >= 6)) begin errors++; $display("FAIL press_level c%0d: got %b expected %b", i, btn_level[2], (i >= 6)); end
      checks++; if (btn_press[2] !== (i == 6)) begin errors++; $display("FAIL press_pulse c%0d: got %b expected %b", i, btn_press[2], (i == 6)); end
    end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL press_single_evt: got %0d events expected 1", obs_q.size()); end
    btn_in[2] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (btn_level[2] !== (i < 6)) begin errors++; $display("FAIL rel_level c%0d: got %b expected %b", i, btn_level[2], (i < 6)); end
      checks++; if (btn_release[2] !== (i == 6)) begin errors++; $display("FAIL rel_pulse c%0d: got %b expected %b", i, btn_release[2], (i == 6)); end
    end
    cycles(4);
    exp_q.push_back(ev(2, EVT_PRESS));
    exp_q.push_back(ev(2, EVT_RELEASE));
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL press_evt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL press_evt[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounce();
    evt_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 4; j++) begin
        btn_in[0] = (j < 3);
        @(negedge clk);
        checks++; if (btn_level[0] !== 1'b0) begin errors++; $display("FAIL bounce_level r%0d j%0d: got %b expected 0", r, j, btn_level[0]); end
        checks++; if (btn_press[0] !== 1'b0) begin errors++; $display("FAIL bounce_press r%0d j%0d: got %b expected 0", r, j, btn_press[0]); end
      end
    end
    btn_in[0] = 1'b0;
    cycles(8);
    checks++; if (btn_level[0] !== 1'b0) begin errors++; $display("FAIL bounce_level_end: got %b expected 0", btn_level[0]); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bounce_events: got %0d expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_long_press();
    evt_ready = 1'b1;
    btn_in[1] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 6) begin
        checks++; if (btn_level[1] !== 1'b1) begin errors++; $display("FAIL long_rise: got %b expected 1", btn_level[1]); end
      end
      if (i == 25) begin
        checks++; if (dbg_state[1] !== ST_HELD) begin errors++; $display("FAIL long_state_held: got %0d expected %0d", dbg_state[1], ST_HELD); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL long_not_early: got %0d events expected 1", obs_q.size()); end
      end
      if (i == 26) begin
        checks++; if (dbg_state[1] !== ST_LONG) begin errors++; $display("FAIL long_state_long: got %0d expected %0d", dbg_state[1], ST_LONG); end
      end
      if (i == 30) begin
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL long_arrived: got %0d events expected 2", obs_q.size()); end
      end
    end
    btn_in[1] = 1'b0;
    cycles(12);
    exp_q.push_back(ev(1, EVT_PRESS));
    exp_q.push_back(ev(1, EVT_LONG));
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    exp_q.push_back(ev(1, EVT_REPEAT));
`endif
    exp_q.push_back(ev(1, EVT_RELEASE));
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL long_evt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL long_evt[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
    end
    checks++; if (dbg_state[1] !== ST_RELEASED) begin errors++; $display("FAIL long_state_rel: got %0d expected 0", dbg_state[1]); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    evt_ready = 1'b0;
    btn_in[3] = 1'b1; btn_in[1] = 1'b1;
    for (int k = 0; k < 20 && evt_valid !== 1'b1; k++) @(negedge clk);
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b expected 1", evt_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({evt_valid, evt_ch, evt_type} !== {1'b1, ev(1, EVT_PRESS)}) begin
        errors++; $display("FAIL b2b_hold c%0d: got %h expected %h", i, {evt_valid, evt_ch, evt_type}, {1'b1, ev(1, EVT_PRESS)});
      end
      @(negedge clk);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    for (int k = 0; k < 10 && evt_valid !== 1'b1; k++) @(negedge clk);
    checks++; if ({evt_valid, evt_ch, evt_type} !== {1'b1, ev(3, EVT_PRESS)}) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", {evt_valid, evt_ch, evt_type}, {1'b1, ev(3, EVT_PRESS)});
    end
    btn_in[3] = 1'b0; btn_in[1] = 1'b0;
    evt_ready = 1'b1;
    cycles(14);
    exp_q.push_back(ev(1, EVT_PRESS));
    exp_q.push_back(ev(3, EVT_PRESS));
    exp_q.push_back(ev(1, EVT_RELEASE));
    exp_q.push_back(ev(3, EVT_RELEASE));
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_evt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_evt[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    btn_in[0] = 1'b1; cycles(8);
    btn_in[0] = 1'b0; cycles(8);
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL ovf_first: got %b expected 0", evt_overflow); end
    btn_in[0] = 1'b1; cycles(8);
    checks++; if (evt_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", evt_overflow); end
    btn_in[0] = 1'b0; cycles(8);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", evt_overflow); end
    evt_ready = 1'b1;
    cycles(10);
    exp_q.push_back(ev(0, EVT_PRESS));
    exp_q.push_back(ev(0, EVT_RELEASE));
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_evt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL ovf_evt[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
    end
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL ovf_stays_clear: got %b expected 0", evt_overflow); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    btn_in[1] = 1'b1; cycles(10);
    btn_in[2] = 1'b1; cycles(2);
    checks++; if ({evt_valid, evt_ch, btn_level[1]} !== 4'b1011) begin
      errors++; $display("FAIL mid_pre: got %b expected 1011", {evt_valid, evt_ch, btn_level[1]});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({btn_level, btn_press, btn_release} !== 12'h000) begin errors++; $display("FAIL mid_rst_btn: got %h expected 0", {btn_level, btn_press, btn_release}); end
    checks++; if ({evt_valid, evt_ch, evt_type, evt_overflow} !== 6'h00) begin errors++; $display("FAIL mid_rst_evt: got %h expected 0", {evt_valid, evt_ch, evt_type, evt_overflow}); end
    btn_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cycles(10);
    checks++; if (btn_level !== 4'h0) begin errors++; $display("FAIL mid_after_level: got %h expected 0", btn_level); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_after_events: got %0d expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  task automatic test_repeat();
    evt_ready = 1'b1;
    btn_in[2] = 1'b1; cycles(40);
    btn_in[2] = 1'b0; cycles(12);
    exp_q.push_back(ev(2, EVT_PRESS));
    exp_q.push_back(ev(2, EVT_LONG));
    exp_q.push_back(ev(2, EVT_REPEAT));
    exp_q.push_back(ev(2, EVT_REPEAT));
    exp_q.push_back(ev(2, EVT_RELEASE));
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rep_evt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL rep_evt[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    test_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
